// File: rtl/systolic_feed_skewer.sv
// Feeder for the SIZE x SIZE systolic array: it accepts K-step beats, applies the triangular
// lane skew, and sequences the clear, feed, flush and done phases of each tile.
module systolic_feed_skewer #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]   in_a,
    input  logic [SIZE*DATA_WIDTH-1:0]   in_b,
    output logic [SIZE*DATA_WIDTH-1:0]   west_inputs,
    output logic [SIZE*DATA_WIDTH-1:0]   north_inputs,
    output logic                         accum_reset,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

    localparam int FLUSH_LEN = 2 * SIZE - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    state_t             state;
    logic [K_WIDTH-1:0] k_reg;
    logic [K_WIDTH-1:0] beat_cnt;
    logic [K_WIDTH-1:0] beat_next;
    logic [FW-1:0]      flush_cnt;
    logic               accept;
    logic               skew_clear;

    assign accept     = in_valid && in_ready;
    assign beat_next  = beat_cnt + K_WIDTH'(1);
    assign skew_clear = rst || (state == CLEAR);

    // All control outputs are registered alongside the state, so in_ready never
    // looks at in_valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            k_reg       <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            in_ready    <= 1'b0;
            accum_reset <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len != '0) begin
                            k_reg       <= k_len;
                            beat_cnt    <= '0;
                            accum_reset <= 1'b1;
                            state       <= CLEAR;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    accum_reset <= 1'b0;
                    in_ready    <= 1'b1;
                    state       <= FEED;
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_next;
                        if (beat_next == k_reg) begin
                            in_ready  <= 1'b0;
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Zeros keep flowing until the last product reaches PE(SIZE-1, SIZE-1).
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane i is a shift register with i+1 stages. A cycle with no accepted beat
    // pushes a zero into every lane, which keeps the lanes aligned with each other.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_sr [0:i];
        logic [DATA_WIDTH-1:0] b_sr [0:i];

        always_ff @(posedge clk) begin
            // NOTE: the skew stages are reset explicitly, even though they hold
            // data, because the array edge must see zeros after reset or an abort.
            if (skew_clear) begin
                for (int j = 0; j <= i; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else begin
                a_sr[0] <= accept ? in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                b_sr[0] <= accept ? in_b[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                end
            end
        end

        assign west_inputs[i*DATA_WIDTH +: DATA_WIDTH]  = a_sr[i];
        assign north_inputs[i*DATA_WIDTH +: DATA_WIDTH] = b_sr[i];
    end

endmodule

// File: tb/tb_systolic_feed_skewer.sv
// Bench for systolic_feed_skewer: a behavioural output-stationary array driven by the skewed
// edges, plus a scoreboard of per-tile expectations (done cycle and all PE results).
module tb_systolic_feed_skewer;

    localparam int SIZE = 16;
    localparam int DW   = 8;
    localparam int KW   = 16;
    localparam int VW   = SIZE * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_a = '0;
    logic [VW-1:0] in_b = '0;
    logic [VW-1:0] west_inputs;
    logic [VW-1:0] north_inputs;
    logic          accum_reset;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            done_rel;
        int            k;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } exp_t;

    exp_t sb[$];

    systolic_feed_skewer #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .west_inputs  (west_inputs),
        .north_inputs (north_inputs),
        .accum_reset  (accum_reset),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Output-stationary array: operands move east/south one PE per cycle.
    int acc   [SIZE][SIZE];
    int a_reg [SIZE][SIZE];
    int b_reg [SIZE][SIZE];

    function automatic int a_at(int r, int c);
        if (c == 0) return int'($signed(west_inputs[r*DW +: DW]));
        return a_reg[r][c-1];
    endfunction

    function automatic int b_at(int r, int c);
        if (r == 0) return int'($signed(north_inputs[c*DW +: DW]));
        return b_reg[r-1][c];
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                a_reg[r][c] <= a_at(r, c);
                b_reg[r][c] <= b_at(r, c);
                acc[r][c]   <= accum_reset ? 0 : acc[r][c] + a_at(r, c) * b_at(r, c);
            end
        end
    end

    task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [271:0] all_outs();
        return {8'h0, west_inputs, north_inputs, in_ready, accum_reset, busy, done};
    endfunction

    // Runs one tile. The same a/b vectors are presented for every beat; stall_len
    // idle cycles are inserted once stall_after beats have been accepted.
    task automatic run_tile(input int k, input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input int stall_after, input int stall_len, input int exp_done,
                            input bit check_skew, input bit check_res);
        exp_t e;
        int   rel = 0, beat = 0, stalls = stall_len;
        int   got_done = -1, ar_rel = -1, ready_cycles = 0;
        bit   busy_at_done = 0;
        logic [VW-1:0] ew, en;

        e.done_rel = exp_done; e.k = k; e.a = a; e.b = b;
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        while (rel < 200 && got_done < 0) begin
            if (rel > 0) start = 1'b0;
            if (done) begin
                got_done     = rel;
                busy_at_done = busy;
            end
            if (accum_reset && ar_rel < 0) ar_rel = rel;
            if (in_ready) ready_cycles++;
            if (check_skew && rel >= 2 && rel <= 20) begin
                ew = '0;
                en = '0;
                for (int i = 0; i < SIZE; i++) begin
                    if (rel == 3 + i) begin
                        ew[i*DW +: DW] = a[i*DW +: DW];
                        en[i*DW +: DW] = b[i*DW +: DW];
                    end
                end
                check($sformatf("west_c%0d", rel), {144'h0, west_inputs}, {144'h0, ew});
                check($sformatf("north_c%0d", rel), {144'h0, north_inputs}, {144'h0, en});
            end
            if (in_ready && beat < k) begin
                if (beat == stall_after && stalls > 0) begin
                    in_valid = 1'b0;
                    stalls--;
                end else begin
                    in_valid = 1'b1;
                    in_a     = a;
                    in_b     = b;
                    beat++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            rel++;
        end
        in_valid = 1'b0;
        start    = 1'b0;

        e = sb.pop_front();
        check("done_cycle", 272'(got_done), 272'(e.done_rel));
        check("busy_at_done", 272'(busy_at_done), 272'(1));
        check("done_pulse_end", {done, busy}, 272'(0));
        check("accum_reset_cycle", 272'(ar_rel), (e.k != 0) ? 272'(1) : 272'(-1));
        check("ready_cycles", 272'(ready_cycles), (e.k != 0) ? 272'(e.k + stall_len) : 272'(0));
        if (check_res) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    check($sformatf("pe_%0d_%0d", r, c), 272'(acc[r][c]),
                          272'(e.k * $signed(e.a[r*DW +: DW]) * $signed(e.b[c*DW +: DW])));
        end
    endtask

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] v);
        logic [VW-1:0] x;
        for (int i = 0; i < SIZE; i++) x[i*DW +: DW] = v;
        return x;
    endfunction

    initial begin
        logic [VW-1:0] sa, sbv;
        bit            saw_done;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outs", all_outs(), '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle_%0d", i), all_outs(), '0);
        end

        for (int i = 0; i < SIZE; i++) begin
            sa[i*DW +: DW]  = DW'(i + 1);
            sbv[i*DW +: DW] = DW'(8'h10 + i);
        end
        run_tile(1, sa, sbv, 99, 0, 34, 1'b1, 1'b0);

        run_tile(4, splat(8'd1), splat(8'd2), 99, 0, 37, 1'b0, 1'b1);
        run_tile(4, splat(8'd1), splat(8'd2), 2, 3, 40, 1'b0, 1'b1);
        run_tile(0, splat(8'd0), splat(8'd0), 99, 0, 1, 1'b0, 1'b0);

        // Abort: reset during cycle 10 of a k_len=8 tile.
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(8);
        for (int rel = 0; rel <= 10; rel++) begin
            if (rel > 0) start = 1'b0;
            in_valid = in_ready;
            in_a     = splat(8'd5);
            in_b     = splat(8'd7);
            if (rel == 10) rst = 1'b1;
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_idle", all_outs(), '0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("abort_no_done", 272'(saw_done), 272'(0));

        run_tile(2, splat(8'd3), splat(8'hFF), 99, 0, 35, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feed_skewer.md
Name: systolic_feed_skewer

Overview:
- Upstream feeder for the 16x16 INT8 systolic array.
- Accepts one K-step per beat over a valid/ready stream: an activation column vector (one byte per array row) paired with a weight row vector (one byte per array column).
- Applies the triangular skew (lane i delayed i cycles) and drives the array's west_inputs, north_inputs and accum_reset.
- Sequences clear, feed and zero-flush per tile, then pulses done once all 256 PE results are final.

Parameters:
- SIZE, 16, array dimension and number of lanes per vector.
- DATA_WIDTH, 8, signed operand width per lane.
- K_WIDTH, 16, width of the tile depth (K) counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a tile; sampled only in IDLE.
- k_len  input  K_WIDTH  number of K beats in the tile; latched on start.
- in_valid  input  1  in_a/in_b hold a valid beat.
- in_ready  output  1  beat accepted when in_valid and in_ready are both high.
- in_a  input  SIZE*DATA_WIDTH  activation lanes; lane r = in_a[r*DATA_WIDTH +: DATA_WIDTH], feeds array row r.
- in_b  input  SIZE*DATA_WIDTH  weight lanes; lane c = in_b[c*DATA_WIDTH +: DATA_WIDTH], feeds array column c.
- west_inputs  output  SIZE*DATA_WIDTH  skewed activations to the array west edge.
- north_inputs  output  SIZE*DATA_WIDTH  skewed weights to the array north edge.
- accum_reset  output  1  clears all PE accumulators.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the tile's results are final.

Behaviour:
- Reset: state=IDLE; all skew registers and outputs are 0 (west/north all zero; in_ready, accum_reset, busy, done = 0).
- rst mid-tile aborts immediately: next cycle is IDLE with the skew pipeline zeroed and no done pulse.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DONE.
  - IDLE: start=1 with k_len!=0 latches k_len, clears the beat counter, goes to CLEAR. start=1 with k_len==0 goes to DONE. start is ignored in all other states.
  - CLEAR (1 cycle): accum_reset=1; skew pipeline zeroed; go to FEED.
  - FEED: in_ready=1. Each accepted beat increments the beat counter. When the accepted beat makes the count equal k_len, go to FLUSH on the next cycle; in_ready is 0 from that cycle onward.
  - FLUSH: lasts exactly 2*SIZE-1 cycles (31), pushing zeros, then goes to DONE.
  - DONE (1 cycle): done=1, then IDLE.
- Skew pipeline: advances every cycle in all states.
  - Lane i input is the accepted beat's lane i data, or 0 when no beat is accepted (stall bubble or non-FEED state).
  - Output lane i at cycle t = lane i input captured at cycle t-1-i. Lane 0 therefore has 1 register stage and lane SIZE-1 has SIZE stages.
  - Identical delay structure on the west and north sides.
- Stalls (in_valid=0 during FEED) insert a zero bubble in every lane simultaneously. Relative alignment is preserved, so a[r][k] and b[k][c] still meet at PE(r,c), and bubbles contribute 0 to the sum.
- Data passes through unmodified (signed, no arithmetic); no width changes.
- Timing with no stalls and start sampled at cycle 0:
  - accum_reset high at cycle 1.
  - Beats accepted at cycles 2..k_len+1.
  - done at cycle k_len+2*SIZE+1.
- Each stall cycle delays done by exactly 1.
- in_ready does not depend combinationally on in_valid.

Test Plan:
- Reset values: hold rst 3 cycles, release -> all outputs 0, state IDLE; start=0 for 10 cycles -> outputs stay 0.
- Skew timing: k_len=1, beat with in_a lanes = r+1 and in_b lanes = 0x10+c, accepted at cycle 2 -> west lane r = r+1 only at cycle 3+r; north lane c = 0x10+c only at cycle 3+c; zero otherwise; done at cycle 34.
- Full tile with the array: k_len=4, in_a all 1, in_b all 2, no stalls -> accum_reset at cycle 1, done at cycle 37, all 256 results = 8.
- Stalls: same tile with in_valid low 3 cycles between beats 2 and 3 -> done at cycle 40, all 256 results still 8.
- k_len=0: start -> no accum_reset, no in_ready; done pulses at cycle 1; busy high for that cycle only.
- Abort/restart: rst at cycle 10 of a k_len=8 tile -> IDLE next cycle, skew outputs zero, no done. A new start with k_len=2, in_a=3, in_b=-1 -> all results = -6.
